calc_accum: RTL and testbench

- Sequential calculator core directly downstream of the 3-button op encoder.
- Consumes the encoder's 4-bit ALU op code and a 16-bit switch operand. A debounced "execute" button applies `acc <= acc OP operand`; a debounced "clear" button zeroes the accumulator.
- Drives the LED bank and status flags.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 66 ++++++
 rtl/calc_accum.sv | 172 +++++++++++++++++
 tb/tb_calc_accum.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
//   Shared definitions for the accumulator calculator core:
//     - 4-bit ALU op codes produced by the upstream 3-button op encoder
//     - FSM state encoding for calc_accum
//     - helper that classifies an op code as legal or not
// -----------------------------------------------------------------------------
package calc_pkg;

  // ALU op codes. Any other 4-bit value is illegal and leaves acc untouched.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1101;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB,
      OP_XOR, OP_NOR, OP_NAND, OP_XNOR: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw, asynchronous, active-high push button.
//     - 2-flop synchroniser
//     - counter that must see DEB_CYCLES consecutive disagreements between
//       the synchronised level and the debounced level before flipping it
//     - single-cycle rising-edge pulse of the debounced level
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw button input (asynchronous)
//   level  out  debounced button level
//   rise   out  one-cycle pulse on each debounced 0->1 transition
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_q;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples the pre-edge value of its neighbours; blocking
  // assignments here would collapse the synchroniser into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b != level) begin
        // The edge on which the count would reach DEB_CYCLES flips the level.
        if (cnt == CNT_LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Any agreement restarts the qualification window, so short glitches
        // never accumulate across bounces.
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/calc_accum.sv
// -----------------------------------------------------------------------------
// calc_accum
//   Sequential calculator core. A debounced execute button applies
//   acc <= acc OP operand once per press; a debounced clear button zeroes the
//   accumulator and flags in any state.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   alu_op    in   4-bit op code from the encoder (quasi-static)
//   operand   in   WIDTH-bit switch value (quasi-static)
//   btn_exec  in   raw execute button, asynchronous, active-high
//   btn_clr   in   raw clear button, asynchronous, active-high
//   led       out  accumulator value
//   zero      out  accumulator == 0
//   ovf       out  signed overflow of the last ADD/SUB
//   bad_op    out  last executed op code was illegal
//   busy      out  sequencer not in IDLE
// -----------------------------------------------------------------------------
module calc_accum
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand,
  input  logic             btn_exec,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] led,
  output logic             zero,
  output logic             ovf,
  output logic             bad_op,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic exec_level;
  logic exec_rise;
  logic clr_level;
  logic clr_rise;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_exec (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_exec),
    .level (exec_level),
    .rise  (exec_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_clr),
    .level (clr_level),
    .rise  (clr_rise)
  );

  // The clear path only needs the pulse; the level is kept for visibility.
  logic clr_level_unused;
  assign clr_level_unused = clr_level;

  // ---------------------------------------------------------------------------
  // Sequencer: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   exec_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written in an always_comb block is given a default
  // first, so no path through the case can leave it unassigned and infer a
  // latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (exec_rise)   state_nxt = S_EXEC;
      S_EXEC:                      state_nxt = S_WAIT_REL;
      // Holding the button keeps us here, so one press executes once.
      S_WAIT_REL: if (!exec_level) state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    exec_en = 1'b0;
    busy    = 1'b1;
    case (state)
      S_IDLE:  busy    = 1'b0;
      S_EXEC:  exec_en = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: combinational, only consumed while in EXEC
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_bad;

  assign sum  = acc + operand;
  assign diff = acc - operand;

  always_comb begin
    alu_res = acc;
    alu_ovf = 1'b0;
    alu_bad = 1'b0;
    case (alu_op)
      OP_AND:  alu_res = acc & operand;
      OP_OR:   alu_res = acc | operand;
      OP_XOR:  alu_res = acc ^ operand;
      OP_NOR:  alu_res = ~(acc | operand);
      OP_NAND: alu_res = ~(acc & operand);
      OP_XNOR: alu_res = ~(acc ^ operand);
      OP_ADD: begin
        alu_res = sum;
        // Like-signed operands producing a result of the other sign.
        alu_ovf = (acc[MSB] == operand[MSB]) && (sum[MSB] != acc[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        // Unlike-signed operands producing a result whose sign left acc's.
        alu_ovf = (acc[MSB] != operand[MSB]) && (diff[MSB] != acc[MSB]);
      end
      default: alu_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator and flags
  // ---------------------------------------------------------------------------
  // NOTE: the asynchronous reset clears every register here, including acc,
  // so a reset mid-operation leaves no partially updated result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      ovf    <= 1'b0;
      bad_op <= 1'b0;
    end else if (clr_rise) begin
      // Clear outranks a coincident execute; the sequencer still advances.
      acc    <= '0;
      ovf    <= 1'b0;
      bad_op <= 1'b0;
    end else if (exec_en) begin
      acc    <= alu_res;
      ovf    <= alu_ovf;
      bad_op <= alu_bad;
    end
  end

  // Sanity: the legality helper and the ALU decode must agree.
  logic legal_unused;
  assign legal_unused = is_legal_op(alu_op) ^ alu_bad;

  assign led  = acc;
  assign zero = (acc == '0);

endmodule

// File: tb/tb_calc_accum.sv
// -----------------------------------------------------------------------------
// tb_calc_accum
//   Self-checking bench for calc_accum with DEB_CYCLES=4, WIDTH=16.
//   Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_calc_accum;

  localparam int DEB = 4;
  localparam int W   = 16;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_XOR  = 4'b0111;
  localparam logic [3:0] C_NOR  = 4'b1001;
  localparam logic [3:0] C_NAND = 4'b1010;
  localparam logic [3:0] C_XNOR = 4'b1101;

  logic         clk;
  logic         rst_n;
  logic [3:0]   alu_op;
  logic [W-1:0] operand;
  logic         btn_exec;
  logic         btn_clr;
  logic [W-1:0] led;
  logic         zero;
  logic         ovf;
  logic         bad_op;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  calc_accum #(.DEB_CYCLES(DEB), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_op   (alu_op),
    .operand  (operand),
    .btn_exec (btn_exec),
    .btn_clr  (btn_clr),
    .led      (led),
    .zero     (zero),
    .ovf      (ovf),
    .bad_op   (bad_op),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One full press/release of the execute button with bounded waits.
  task automatic do_exec(input logic [3:0] op, input logic [W-1:0] opd);
    int t;
    alu_op   = op;
    operand  = opd;
    btn_exec = 1'b1;
    t = 0;
    while (!busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("exec_start_timeout", 32'(t < 40), 32'd1);
    repeat (4) @(negedge clk);
    btn_exec = 1'b0;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("exec_release_timeout", 32'(t < 40), 32'd1);
    // Disturb the inputs while idle; they must have no effect.
    alu_op  = ~op;
    operand = ~opd;
  endtask

  task automatic do_clear();
    btn_clr = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    btn_clr = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] opd;
    logic [W-1:0] exp_led;
    logic         exp_ovf;
    logic         exp_bad;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    logic [W-1:0] prev_led;
    int           changes;
    logic         any_busy;
    int           t;

    // Accumulator sequence starting from 0 after a clear.
    vecs[0]  = '{C_ADD,  16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    vecs[1]  = '{C_ADD,  16'h0001, 16'h8000, 1'b1, 1'b0};
    vecs[2]  = '{C_SUB,  16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[3]  = '{C_AND,  16'h00FF, 16'h00FF, 1'b0, 1'b0};
    vecs[4]  = '{C_OR,   16'h0F00, 16'h0FFF, 1'b0, 1'b0};
    vecs[5]  = '{C_XOR,  16'h00F0, 16'h0F0F, 1'b0, 1'b0};
    vecs[6]  = '{C_NOR,  16'hF000, 16'h00F0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0011,16'h1234, 16'h00F0, 1'b0, 1'b1};
    vecs[8]  = '{C_OR,   16'h000F, 16'h00FF, 1'b0, 1'b0};
    vecs[9]  = '{C_NAND, 16'h0F0F, 16'hFFF0, 1'b0, 1'b0};
    vecs[10] = '{C_XNOR, 16'h00F0, 16'h00FF, 1'b0, 1'b0};
    vecs[11] = '{C_SUB,  16'h0100, 16'hFFFF, 1'b0, 1'b0};
    vecs[12] = '{C_ADD,  16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{C_ADD,  16'h8000, 16'h8000, 1'b0, 1'b0};
    vecs[14] = '{C_ADD,  16'h8000, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{4'b1111,16'h5555, 16'h0000, 1'b0, 1'b1};

    rst_n    = 1'b0;
    alu_op   = 4'h0;
    operand  = '0;
    btn_exec = 1'b0;
    btn_clr  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_led",    32'(led),    32'h0);
    check("rst_zero",   32'(zero),   32'd1);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_bad_op", 32'(bad_op), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: edge 1 is the first posedge sampling btn_exec=1.
    alu_op   = C_ADD;
    operand  = 16'h0005;
    btn_exec = 1'b1;
    prev_led = led;
    changes  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (led !== prev_led) changes++;
      prev_led = led;
      if (k == 6) check("lat_busy_e6", 32'(busy), 32'd0);
      if (k == 7) begin
        check("lat_led_e7",  32'(led),  32'h0);
        check("lat_busy_e7", 32'(busy), 32'd1);
      end
      if (k == 8) check("lat_led_e8", 32'(led), 32'h0005);
    end
    check("lat_single_update", 32'(changes), 32'd1);
    btn_exec = 1'b0;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("lat_busy_release", 32'(busy), 32'd0);
    check("lat_led_final",    32'(led),  32'h0005);

    // Table-driven op sequence.
    do_clear();
    check("clr_led",  32'(led),  32'h0);
    check("clr_zero", 32'(zero), 32'd1);
    for (int i = 0; i < NV; i++) begin
      do_exec(vecs[i].op, vecs[i].opd);
      check($sformatf("vec%0d_led", i),  32'(led),    32'(vecs[i].exp_led));
      check($sformatf("vec%0d_ovf", i),  32'(ovf),    32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_bad", i),  32'(bad_op), 32'(vecs[i].exp_bad));
      check($sformatf("vec%0d_zero", i), 32'(zero),   32'(vecs[i].exp_led == '0));
    end

    // Glitches shorter than DEB cycles: high 3, low 3, high 2.
    alu_op   = C_ADD;
    operand  = 16'h0001;
    prev_led = led;
    any_busy = 1'b0;
    btn_exec = 1'b1;
    repeat (3) @(negedge clk);
    btn_exec = 1'b0;
    repeat (3) @(negedge clk);
    btn_exec = 1'b1;
    repeat (2) @(negedge clk);
    btn_exec = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy) any_busy = 1'b1;
    end
    check("glitch_no_busy", 32'(any_busy), 32'd0);
    check("glitch_led",     32'(led),      32'(prev_led));

    // Clear pulse landing on the EXEC exit edge of an ADD of 3.
    do_clear();
    do_exec(C_ADD, 16'h0005);
    check("cc_pre_led", 32'(led), 32'h0005);
    alu_op   = C_ADD;
    operand  = 16'h0003;
    btn_exec = 1'b1;
    @(negedge clk);           // edge 1 passed
    btn_clr = 1'b1;           // first sampled at exec edge 2
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        check("cc_led_e7",  32'(led),  32'h0005);
        check("cc_busy_e7", 32'(busy), 32'd1);
      end
    end
    check("cc_led_e8",  32'(led),  32'h0000);
    check("cc_zero_e8", 32'(zero), 32'd1);
    repeat (4) @(negedge clk);
    check("cc_wait_busy", 32'(busy), 32'd1);
    check("cc_wait_led",  32'(led),  32'h0000);
    btn_exec = 1'b0;
    btn_clr  = 1'b0;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("cc_idle", 32'(busy), 32'd0);
    repeat (DEB + 4) @(negedge clk);

    // Asynchronous reset while waiting for release with acc=0x1234.
    do_exec(C_ADD, 16'h1234);
    check("rm_pre_led", 32'(led), 32'h1234);
    alu_op   = C_OR;
    operand  = 16'h0000;
    btn_exec = 1'b1;
    t = 0;
    while (!busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("rm_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_led",  32'(led),  32'h0);
    check("rm_zero", 32'(zero), 32'd1);
    check("rm_busy", 32'(busy), 32'd0);
    btn_exec = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rm_idle_busy", 32'(busy), 32'd0);
    check("rm_idle_led",  32'(led),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
